// File: rtl/fetch_sequencer_pkg.sv
// Shared widths and helpers for the instruction-fetch sequencer.
// Holds the word/address widths and the wait-counter width.
package fetch_sequencer_pkg;

  localparam int WORD_LEN     = 32;
  localparam int ADDRESS_LEN  = 32;
  localparam int FETCH_WAIT_W = 4;

  // One action is chosen per cycle, in priority order: branch > capture > count > hold.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_BRANCH  = 2'd1,
    ACT_CAPTURE = 2'd2,
    ACT_COUNT   = 2'd3
  } fetch_action_e;

  function automatic logic [ADDRESS_LEN-1:0] word_align(input logic [ADDRESS_LEN-1:0] addr);
    return {addr[ADDRESS_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Wait-state counter for one memory access: sync clear, enable, and a
// terminal compare against WAIT_STATES.
module fetch_wait_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [FETCH_WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == FETCH_WAIT_W'(WAIT_STATES));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, paces each access with wait states and
// delivers fetched words to IF/ID through a registered valid/ready output.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_addr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WORD_LEN-1:0]    out_instruction,
  output logic [ADDRESS_LEN-1:0] out_pc,
  output logic [ADDRESS_LEN-1:0] mem_address,
  input  logic [WORD_LEN-1:0]    mem_instruction
);

  logic [ADDRESS_LEN-1:0] pc;
  logic [ADDRESS_LEN-1:0] pc_plus4;
  logic                   done;
  logic                   cnt_clear;
  logic                   cnt_enable;
  fetch_action_e          action;

  assign pc_plus4    = pc + ADDRESS_LEN'(4);
  assign mem_address = word_align(pc);

  always_comb begin
    action = ACT_HOLD;
    if (branch_taken) begin
      action = ACT_BRANCH;
    end else if (done && (!out_valid || out_ready)) begin
      action = ACT_CAPTURE;
    end else if (!done) begin
      action = ACT_COUNT;
    end
  end

  assign cnt_clear  = (action == ACT_BRANCH) || (action == ACT_CAPTURE);
  assign cnt_enable = (action == ACT_COUNT);

  fetch_wait_counter #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= '0;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
    end else begin
      unique case (action)
        // A redirect squashes any held word, even if IF/ID is ready this cycle.
        ACT_BRANCH: begin
          pc        <= word_align(branch_addr);
          out_valid <= 1'b0;
        end
        ACT_CAPTURE: begin
          out_instruction <= mem_instruction;
          out_pc          <= pc_plus4;
          out_valid       <= 1'b1;
          pc              <= pc_plus4;
        end
        ACT_COUNT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ACT_HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios on a 1-wait-state and a
// 0-wait-state instance, then randomized traffic against a cycle model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        out_ready;

  logic        v1, v0;
  logic [31:0] ins1, ins0, opc1, opc0, maddr1, maddr0, mins1, mins0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign mins1 = mem_word(maddr1);
  assign mins0 = mem_word(maddr0);

  fetch_sequencer #(.WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .out_ready(out_ready), .out_valid(v1), .out_instruction(ins1), .out_pc(opc1),
    .mem_address(maddr1), .mem_instruction(mins1)
  );

  fetch_sequencer #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .out_ready(out_ready), .out_valid(v0), .out_instruction(ins0), .out_pc(opc0),
    .mem_address(maddr0), .mem_instruction(mins0)
  );

  // Advance one cycle; returns at the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench in cycle 0 (first cycle with rst low).
  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    checks++;
    if ({v1, ins1, opc1, maddr1} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_ws1 got v=%0b ins=%h pc=%h addr=%h want all 0", v1, ins1, opc1, maddr1);
    end
    checks++;
    if ({v0, ins0, opc0, maddr0} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_ws0 got v=%0b ins=%h pc=%h addr=%h want all 0", v0, ins0, opc0, maddr0);
    end
  endtask

  task automatic test_free_run();
    logic [32:0] exp [1:4];
    exp[1] = {1'b0, 32'h0};
    exp[2] = {1'b1, 32'h4};
    exp[3] = {1'b0, 32'h4};
    exp[4] = {1'b1, 32'h8};
    out_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if ({v1, opc1} !== exp[c]) begin
        errors++;
        $display("FAIL free_run_c%0d got v=%0b pc=%h want v=%0b pc=%h", c, v1, opc1, exp[c][32], exp[c][31:0]);
      end
      if (exp[c][32]) begin
        checks++;
        if (ins1 !== (exp[c][31:0] >> 2) - 32'd1) begin
          errors++;
          $display("FAIL free_run_ins_c%0d got %h want %h", c, ins1, (exp[c][31:0] >> 2) - 32'd1);
        end
      end
    end
  endtask

  task automatic test_zero_wait();
    out_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if ({v0, opc0, ins0} !== {1'b1, 32'(4 * k), 32'(k - 1)}) begin
        errors++;
        $display("FAIL zero_wait_c%0d got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 k, v0, opc0, ins0, 32'(4 * k), 32'(k - 1));
      end
    end
  endtask

  task automatic test_freeze();
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({v1, ins1, opc1, maddr1} !== {1'b1, 32'h0, 32'h4, 32'h4}) begin
        errors++;
        $display("FAIL freeze_hold_%0d got v=%0b ins=%h pc=%h addr=%h want v=1 ins=0 pc=4 addr=4",
                 k, v1, ins1, opc1, maddr1);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({v1, ins1, opc1, maddr1} !== {1'b1, 32'h1, 32'h8, 32'h8}) begin
      errors++;
      $display("FAIL freeze_release got v=%0b ins=%h pc=%h addr=%h want v=1 ins=1 pc=8 addr=8",
               v1, ins1, opc1, maddr1);
    end
  endtask

  task automatic test_branch_squash();
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    branch_taken = 1'b1;
    branch_addr = 32'h0000_0043;
    step();
    branch_taken = 1'b0;
    checks++;
    if ({v1, maddr1, v0, maddr0} !== {1'b0, 32'h40, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL squash_next got v1=%0b a1=%h v0=%0b a0=%h want v=0 addr=40",
               v1, maddr1, v0, maddr0);
    end
    step();
    checks++;
    if ({v1, v0, opc0, ins0} !== {1'b0, 1'b1, 32'h44, 32'h10}) begin
      errors++;
      $display("FAIL squash_ws0_first got v1=%0b v0=%0b pc0=%h ins0=%h want 0 1 44 10",
               v1, v0, opc0, ins0);
    end
    step();
    checks++;
    if ({v1, opc1, ins1} !== {1'b1, 32'h44, 32'h10}) begin
      errors++;
      $display("FAIL squash_ws1_first got v=%0b pc=%h ins=%h want v=1 pc=44 ins=10", v1, opc1, ins1);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    branch_taken = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    checks++;
    if (maddr1 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_addr got %h want fffffffc", maddr1);
    end
    step();
    checks++;
    if ({v0, opc0, ins0, maddr0} !== {1'b1, 32'h0, 32'h3FFF_FFFF, 32'h0}) begin
      errors++;
      $display("FAIL wrap_ws0 got v=%0b pc=%h ins=%h addr=%h want 1 0 3fffffff 0", v0, opc0, ins0, maddr0);
    end
    step();
    checks++;
    if ({v1, opc1, ins1, maddr1} !== {1'b1, 32'h0, 32'h3FFF_FFFF, 32'h0}) begin
      errors++;
      $display("FAIL wrap_ws1 got v=%0b pc=%h ins=%h addr=%h want 1 0 3fffffff 0", v1, opc1, ins1, maddr1);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    checks++;
    if ({v1, opc1} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL stall_setup got v=%0b pc=%h want v=1 pc=4", v1, opc1);
    end
    do_reset();
    checks++;
    if ({v1, ins1, opc1, maddr1, v0, ins0, opc0, maddr0} !== '0) begin
      errors++;
      $display("FAIL stall_reset got v1=%0b i1=%h p1=%h a1=%h v0=%0b i0=%h p0=%h a0=%h want all 0",
               v1, ins1, opc1, maddr1, v0, ins0, opc0, maddr0);
    end
    step();
    step();
    checks++;
    if ({v1, ins1, opc1} !== {1'b1, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL stall_restart got v=%0b ins=%h pc=%h want v=1 ins=0 pc=4", v1, ins1, opc1);
    end
  endtask

  // Reference: each access waits ws extra cycles on a stable address; a finished
  // access is delivered only if the output slot is empty or being drained.
  task automatic test_random();
    logic [31:0] m_pc  [2];
    int          m_age [2];
    logic        m_v   [2];
    logic [31:0] m_ins [2];
    logic [31:0] m_opc [2];
    int          ws    [2];
    logic [96:0] obs, exp;
    ws[0] = 1;
    ws[1] = 0;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_age[i] = 0; m_v[i] = 0; m_ins[i] = 0; m_opc[i] = 0;
    end
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      step();
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_pc[i] = 0; m_age[i] = 0; m_v[i] = 0; m_ins[i] = 0; m_opc[i] = 0;
        end else if (branch_taken) begin
          m_pc[i] = branch_addr & 32'hFFFF_FFFC;
          m_age[i] = 0;
          m_v[i] = 0;
        end else if (m_age[i] >= ws[i]) begin
          if (!m_v[i] || out_ready) begin
            m_ins[i] = mem_word(m_pc[i]);
            m_opc[i] = m_pc[i] + 32'd4;
            m_pc[i] = m_pc[i] + 32'd4;
            m_v[i] = 1;
            m_age[i] = 0;
          end
        end else begin
          if (m_v[i] && out_ready) m_v[i] = 0;
          m_age[i]++;
        end
        obs = (i == 0) ? {v1, ins1, opc1, maddr1} : {v0, ins0, opc0, maddr0};
        exp = {m_v[i], m_ins[i], m_opc[i], m_pc[i]};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random_ws%0d_n%0d got v=%0b ins=%h pc=%h addr=%h want v=%0b ins=%h pc=%h addr=%h",
                   ws[i], n, obs[96], obs[95:64], obs[63:32], obs[31:0],
                   exp[96], exp[95:64], exp[63:32], exp[31:0]);
        end
      end
    end
    rst = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_free_run();
    test_zero_wait();
    test_freeze();
    test_branch_squash();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the instruction-fetch stage: owns the program counter, drives the instruction memory address, waits a parameterised number of wait states per access, and hands fetched words to the IF/ID boundary over a valid/ready handshake. It sits between the pipeline hazard/branch logic and `Instruction_Memory`. It replaces the bare PC register and adder in the fetch stage, so that slower instruction memories and pipeline freezes are handled in one place.

## Interface
- `WAIT_STATES`, default 1: extra cycles the memory address must be held stable before `mem_instruction` is valid. Legal range 0–15.
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `branch_taken`  in  1: redirect request from the execute stage; highest priority after `rst`.
- `branch_addr`  in  `ADDRESS_LEN`: redirect target; bits [1:0] are ignored and treated as 0.
- `out_ready`  in  1: IF/ID register can accept. It is low while the pipeline is frozen.
- `out_valid`  out  1: `out_instruction` and `out_pc` hold a valid fetched word.
- `out_instruction`  out  `WORD_LEN`: fetched instruction.
- `out_pc`  out  `ADDRESS_LEN`: address of the fetched instruction + 4.
- `mem_address`  out  `ADDRESS_LEN`: byte address to `Instruction_Memory`. It is always word-aligned, {pc[31:2], 2'b00}.
- `mem_instruction`  in  `WORD_LEN`: combinational read data from memory.

## Operation
- **Internal state:**
  - `pc` (`ADDRESS_LEN`).
  - Wait counter `cnt` (4 bits).
  - Output register `out_valid`/`out_instruction`/`out_pc`.
- **`done`:** defined as `cnt == WAIT_STATES`. `mem_address` is driven from `pc` continuously.
- **Per-cycle priority:** `rst` > `branch_taken` > capture > count.
  - **`rst`:** `pc`=0, `cnt`=0, `out_valid`=0, `out_instruction`=0, `out_pc`=0.
  - **`branch_taken`:**
    - `pc`←{branch_addr[31:2],2'b00} and `cnt`←0.
    - `out_valid`←0 regardless of `out_ready`, which squashes any held word.
    - No capture occurs in that cycle.
  - **Capture:** occurs when `done && (!out_valid || out_ready)`.
    - `out_instruction`←`mem_instruction`.
    - `out_pc`←`pc`+4.
    - `out_valid`←1.
    - `pc`←`pc`+4.
    - `cnt`←0.
  - **Consume without capture:** `out_valid && out_ready && !done` sets `out_valid`←0.
  - **Count:** when `!done`, `cnt`←`cnt`+1.
  - **Stall:** `done` with output full and not ready. `pc`, `cnt`, `mem_address` and the output register all hold.
- **Arithmetic:** PC addition is modulo 2^32, so 0xFFFF_FFFC+4 = 0x0000_0000. No other overflow exists.
- **Simultaneous `branch_taken` and `out_ready`:** the held word is dropped, not delivered.
- **`rst` during a stall or count:** all state returns to reset values on that edge.

## Timing
- Call the first cycle after `rst` deasserts cycle 0. `mem_address`=0 and `cnt`=0 in cycle 0.
- **First `out_valid`:** cycle `WAIT_STATES`+1.
- **Throughput with `out_ready` held high:** one instruction per `WAIT_STATES`+1 cycles. With `WAIT_STATES`=0 this is one per cycle, back-to-back.
- **Redirect latency:** `branch_taken` sampled at the edge ending cycle t gives:
  - `mem_address`=target in cycle t+1;
  - `out_valid` low in cycle t+1;
  - first target word valid in cycle t+2+`WAIT_STATES`.
- **Stability:** `mem_address` is stable for at least `WAIT_STATES`+1 consecutive cycles per fetch.
- All outputs are registered except `mem_address`, which is a registered `pc` with bits [1:0] forced to zero.

## Structure
- `WORD_LEN` and `ADDRESS_LEN` come from the shared `configs.v`.
- Add `` `FETCH_WAIT_W `` (4) to `configs.v` as the counter width.
- Sub-module `fetch_wait_counter` contains the counter with sync clear, enable, and the `done` compare against `WAIT_STATES`.
- The top level holds the PC, the output register and the priority logic.

## Test plan
- **Reset then free-run:** `WAIT_STATES`=1, memory word i = i, `out_ready`=1.
  - `out_valid` first high in cycle 2 with `out_instruction`=0 and `out_pc`=4.
  - Next word is 1 with `out_pc`=8, valid in cycle 4.
- **Zero wait states:** `WAIT_STATES`=0, `out_ready`=1 → `out_valid` high every cycle from cycle 1, with `out_pc` 4, 8, 12, … consecutive.
- **Freeze:**
  - `out_ready`=0 for 5 cycles while a word is held → outputs and `mem_address` are unchanged.
  - After `out_ready` returns to 1, the held word is consumed and the next word is captured on the same edge.
- **Branch squash:** `branch_taken`=1 with `branch_addr`=0x0000_0043 while a word is held and `out_ready`=1.
  - Next cycle: `out_valid`=0 and `mem_address`=0x40.
  - First delivered `out_pc`=0x44.
- **Wrap:** `branch_addr`=0xFFFF_FFFC → delivered `out_pc`=0x0000_0000, and the next `mem_address` is 0.
- **Reset mid-stall:** `rst` pulsed while `out_valid`=1 and `out_ready`=0 → next cycle all outputs are 0, then the fetch restarts at address 0.
